// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the ID-stage hazard sequencer: forward-select codes and FSM states.
package hazard_ctrl_pkg;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_MEM_WAIT = 2'd1,
    HZ_TRAP     = 2'd2
  } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Priority forwarding match for one ID operand: EX over MEM over WB, otherwise register file.
module hazard_ctrl_fwd_sel
  import hazard_ctrl_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic [AW-1:0] rs_i,
  input  logic          rs_used_i,
  input  logic [AW-1:0] ex_waddr_i,
  input  logic          ex_we_i,
  input  logic [AW-1:0] mem_waddr_i,
  input  logic          mem_we_i,
  input  logic [AW-1:0] wb_waddr_i,
  input  logic          wb_we_i,
  output logic [1:0]    sel_o
);

  logic rs_live;

  // x0 is hardwired zero, so it never takes a bypass path
  assign rs_live = rs_used_i && (rs_i != '0);

  always_comb begin
    sel_o = FWD_RF;
    if (rs_live && ex_we_i && (ex_waddr_i == rs_i)) begin
      sel_o = FWD_EX;
    end else if (rs_live && mem_we_i && (mem_waddr_i == rs_i)) begin
      sel_o = FWD_MEM;
    end else if (rs_live && wb_we_i && (wb_waddr_i == rs_i)) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// ID-stage pipeline sequencer: forwarding, load-use stalls, memory wait, redirect and trap flush.
// Defining HAZARD_PERF_EN adds stall/flush cycle counters (stall_cnt_o, flush_cnt_o).
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int AW           = 5,
  parameter int FLUSH_CYCLES = 2,
  parameter int PERF_W       = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [AW-1:0] id_rs1_i,
  input  logic [AW-1:0] id_rs2_i,
  input  logic          id_rs1_used_i,
  input  logic          id_rs2_used_i,
  input  logic          id_branch_op_i,
  input  logic          id_jump_op_i,
  input  logic          id_take_branch_i,
  input  logic [AW-1:0] ex_waddr_i,
  input  logic          ex_we_i,
  input  logic          ex_load_i,
  input  logic [AW-1:0] mem_waddr_i,
  input  logic          mem_we_i,
  input  logic          mem_load_i,
  input  logic [AW-1:0] wb_waddr_i,
  input  logic          wb_we_i,
  input  logic          mem_busy_i,
  input  logic          exc_i,
  output logic [1:0]    forward_a_sel_o,
  output logic [1:0]    forward_b_sel_o,
  output logic          if_stall_o,
  output logic          id_stall_o,
  output logic          id_flush_o,
  output logic          ifid_flush_o,
  output logic          ex_flush_o,
  output logic          mem_stall_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0] stall_cnt_o,
  output logic [PERF_W-1:0] flush_cnt_o
`endif
);

  localparam int              CNT_W    = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  if (FLUSH_CYCLES < 1) begin : g_bad_flush_cycles
    $error("hazard_ctrl: FLUSH_CYCLES must be at least 1");
  end
  if (PERF_W < 1) begin : g_bad_perf_w
    $error("hazard_ctrl: PERF_W must be at least 1");
  end

  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       fwd_a, fwd_b;
  logic             lu_a, lu_b, load_use, redirect;

  hazard_ctrl_fwd_sel #(.AW(AW)) u_fwd_a (
    .rs_i        (id_rs1_i),
    .rs_used_i   (id_rs1_used_i),
    .ex_waddr_i  (ex_waddr_i),
    .ex_we_i     (ex_we_i),
    .mem_waddr_i (mem_waddr_i),
    .mem_we_i    (mem_we_i),
    .wb_waddr_i  (wb_waddr_i),
    .wb_we_i     (wb_we_i),
    .sel_o       (fwd_a)
  );

  hazard_ctrl_fwd_sel #(.AW(AW)) u_fwd_b (
    .rs_i        (id_rs2_i),
    .rs_used_i   (id_rs2_used_i),
    .ex_waddr_i  (ex_waddr_i),
    .ex_we_i     (ex_we_i),
    .mem_waddr_i (mem_waddr_i),
    .mem_we_i    (mem_we_i),
    .wb_waddr_i  (wb_waddr_i),
    .wb_we_i     (wb_we_i),
    .sel_o       (fwd_b)
  );

  // Re-evaluated every cycle, so a load in EX stalls twice and a load in MEM once
  assign lu_a = id_rs1_used_i && (id_rs1_i != '0) &&
                ((ex_load_i && (ex_waddr_i == id_rs1_i)) ||
                 (mem_load_i && (mem_waddr_i == id_rs1_i)));
  assign lu_b = id_rs2_used_i && (id_rs2_i != '0) &&
                ((ex_load_i && (ex_waddr_i == id_rs2_i)) ||
                 (mem_load_i && (mem_waddr_i == id_rs2_i)));
  assign load_use = lu_a || lu_b;
  assign redirect = (id_branch_op_i && id_take_branch_i) || id_jump_op_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= HZ_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      HZ_RUN: begin
        if (exc_i) begin
          state_d = HZ_TRAP;
          cnt_d   = CNT_LOAD;
        end else if (mem_busy_i) begin
          state_d = HZ_MEM_WAIT;
        end
      end
      HZ_MEM_WAIT: begin
        if (exc_i) begin
          state_d = HZ_TRAP;
          cnt_d   = CNT_LOAD;
        end else if (!mem_busy_i) begin
          state_d = HZ_RUN;
        end
      end
      HZ_TRAP: begin
        if (exc_i) begin
          cnt_d = CNT_LOAD;
        end else if (cnt_q == '0) begin
          state_d = mem_busy_i ? HZ_MEM_WAIT : HZ_RUN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = HZ_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are gated by reset so an asserted rst_i silences every strobe immediately
  always_comb begin
    forward_a_sel_o = FWD_RF;
    forward_b_sel_o = FWD_RF;
    if_stall_o      = 1'b0;
    id_stall_o      = 1'b0;
    id_flush_o      = 1'b0;
    ifid_flush_o    = 1'b0;
    ex_flush_o      = 1'b0;
    mem_stall_o     = 1'b0;
    if (rst_i) begin
      forward_a_sel_o = fwd_a;
      forward_b_sel_o = fwd_b;
      if (exc_i || (state_q == HZ_TRAP)) begin
        ifid_flush_o = 1'b1;
        id_flush_o   = 1'b1;
        ex_flush_o   = 1'b1;
      end else if (mem_busy_i) begin
        if_stall_o  = 1'b1;
        id_stall_o  = 1'b1;
        mem_stall_o = 1'b1;
      end else if (load_use) begin
        if_stall_o = 1'b1;
        id_flush_o = 1'b1;
      end else if (redirect) begin
        ifid_flush_o = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + PERF_W'(if_stall_o);
    flush_cnt_d = flush_cnt_q + PERF_W'(ifid_flush_o);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  // No performance counters in this build
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a vector table for single-cycle behaviour plus multi-cycle sequences.
module tb_hazard_ctrl;

  localparam int AW = 5;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [AW-1:0] id_rs1_i, id_rs2_i;
  logic          id_rs1_used_i, id_rs2_used_i;
  logic          id_branch_op_i, id_jump_op_i, id_take_branch_i;
  logic [AW-1:0] ex_waddr_i, mem_waddr_i, wb_waddr_i;
  logic          ex_we_i, ex_load_i, mem_we_i, mem_load_i, wb_we_i;
  logic          mem_busy_i, exc_i;
  logic [1:0]    forward_a_sel_o, forward_b_sel_o;
  logic          if_stall_o, id_stall_o, id_flush_o, ifid_flush_o, ex_flush_o, mem_stall_o;
`ifdef HAZARD_PERF_EN
  logic [31:0]   stall_cnt_o, flush_cnt_o;
`endif

  int errors = 0;
  int checks = 0;

  // Strobe bundle order: {if_stall, id_stall, id_flush, ifid_flush, ex_flush, mem_stall}
  localparam logic [5:0] S_NONE  = 6'b000000;
  localparam logic [5:0] S_LU    = 6'b101000;
  localparam logic [5:0] S_REDIR = 6'b000100;
  localparam logic [5:0] S_BUSY  = 6'b110001;
  localparam logic [5:0] S_TRAP  = 6'b001110;

  typedef struct {
    string      name;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [1:0] used;
    logic [2:0] ctl;
    logic [4:0] exA;
    logic [1:0] exF;
    logic [4:0] memA;
    logic [1:0] memF;
    logic [4:0] wbA;
    logic       wbWe;
    logic       busy;
    logic [1:0] fa;
    logic [1:0] fb;
    logic [5:0] strobes;
  } vec_t;

  vec_t vecs [10];

  hazard_ctrl #(.AW(AW), .FLUSH_CYCLES(2), .PERF_W(32)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .id_rs1_i         (id_rs1_i),
    .id_rs2_i         (id_rs2_i),
    .id_rs1_used_i    (id_rs1_used_i),
    .id_rs2_used_i    (id_rs2_used_i),
    .id_branch_op_i   (id_branch_op_i),
    .id_jump_op_i     (id_jump_op_i),
    .id_take_branch_i (id_take_branch_i),
    .ex_waddr_i       (ex_waddr_i),
    .ex_we_i          (ex_we_i),
    .ex_load_i        (ex_load_i),
    .mem_waddr_i      (mem_waddr_i),
    .mem_we_i         (mem_we_i),
    .mem_load_i       (mem_load_i),
    .wb_waddr_i       (wb_waddr_i),
    .wb_we_i          (wb_we_i),
    .mem_busy_i       (mem_busy_i),
    .exc_i            (exc_i),
    .forward_a_sel_o  (forward_a_sel_o),
    .forward_b_sel_o  (forward_b_sel_o),
    .if_stall_o       (if_stall_o),
    .id_stall_o       (id_stall_o),
    .id_flush_o       (id_flush_o),
    .ifid_flush_o     (ifid_flush_o),
    .ex_flush_o       (ex_flush_o),
    .mem_stall_o      (mem_stall_o)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cnt_o      (stall_cnt_o),
    .flush_cnt_o      (flush_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation ran past 200000 time units, required finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic idleInputs();
    id_rs1_i = '0; id_rs2_i = '0; id_rs1_used_i = 0; id_rs2_used_i = 0;
    id_branch_op_i = 0; id_jump_op_i = 0; id_take_branch_i = 0;
    ex_waddr_i = '0; ex_we_i = 0; ex_load_i = 0;
    mem_waddr_i = '0; mem_we_i = 0; mem_load_i = 0;
    wb_waddr_i = '0; wb_we_i = 0;
    mem_busy_i = 0; exc_i = 0;
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk_i);
    id_rs1_i = v.rs1; id_rs2_i = v.rs2;
    {id_rs1_used_i, id_rs2_used_i} = v.used;
    {id_branch_op_i, id_jump_op_i, id_take_branch_i} = v.ctl;
    ex_waddr_i = v.exA; {ex_we_i, ex_load_i} = v.exF;
    mem_waddr_i = v.memA; {mem_we_i, mem_load_i} = v.memF;
    wb_waddr_i = v.wbA; wb_we_i = v.wbWe;
    mem_busy_i = v.busy; exc_i = 0;
  endtask

  task automatic checkOutput(input string name, input logic [1:0] fa, input logic [1:0] fb,
                             input logic [5:0] strobes);
    logic [5:0] got;
    got = {if_stall_o, id_stall_o, id_flush_o, ifid_flush_o, ex_flush_o, mem_stall_o};
    checks++;
    if (forward_a_sel_o !== fa || forward_b_sel_o !== fb || got !== strobes) begin
      errors++;
      $display("[TB] FAIL %s: got fa=%0d fb=%0d strobes=%b, expected fa=%0d fb=%0d strobes=%b",
               name, forward_a_sel_o, forward_b_sel_o, got, fa, fb, strobes);
    end
  endtask

  // Next negedge with idle inputs, ready for a hand-written sequence step
  task automatic nextCycle();
    @(negedge clk_i);
    idleInputs();
  endtask

  initial begin
    //        name            rs1 rs2 used ctl     exA exF    memA memF   wbA wbWe busy fa fb strobes
    vecs[0] = '{"fwd_ex",       5,  6, 2'b11, 3'b100, 5, 2'b10, 0, 2'b00, 0, 0, 0, 1, 0, S_NONE};
    vecs[1] = '{"fwd_mem_wb",   3,  4, 2'b11, 3'b000, 9, 2'b10, 3, 2'b10, 4, 1, 0, 2, 3, S_NONE};
    vecs[2] = '{"prio_ex",      8,  8, 2'b11, 3'b000, 8, 2'b10, 8, 2'b10, 8, 1, 0, 1, 1, S_NONE};
    vecs[3] = '{"x0_never",     0,  0, 2'b11, 3'b000, 0, 2'b10, 0, 2'b10, 0, 1, 0, 0, 0, S_NONE};
    vecs[4] = '{"rs_unused",    5,  5, 2'b00, 3'b000, 5, 2'b10, 5, 2'b10, 5, 1, 0, 0, 0, S_NONE};
    vecs[5] = '{"ex_we_off",    5,  0, 2'b10, 3'b000, 5, 2'b00, 5, 2'b10, 0, 0, 0, 2, 0, S_NONE};
    vecs[6] = '{"lu_ex_rs2",    0,  7, 2'b01, 3'b000, 7, 2'b11, 0, 2'b00, 0, 0, 0, 0, 1, S_LU};
    vecs[7] = '{"lu_mem_beq",   7,  0, 2'b10, 3'b101, 0, 2'b00, 7, 2'b11, 0, 0, 0, 2, 0, S_LU};
    vecs[8] = '{"jump",         0,  0, 2'b00, 3'b010, 0, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, S_REDIR};
    vecs[9] = '{"busy_jump",    0,  0, 2'b00, 3'b010, 0, 2'b00, 0, 2'b00, 0, 0, 1, 0, 0, S_BUSY};

    // Reset with hazards and an exception present: everything must read zero
    rst_i = 1'b0;
    idleInputs();
    id_rs1_i = 5; id_rs1_used_i = 1; ex_waddr_i = 5; ex_we_i = 1; exc_i = 1; mem_busy_i = 1;
    #12;
    checkOutput("reset_state", 0, 0, S_NONE);
`ifdef HAZARD_PERF_EN
    checks++;
    if (stall_cnt_o !== 0 || flush_cnt_o !== 0) begin
      errors++;
      $display("[TB] FAIL perf_reset: got stall=%0d flush=%0d, expected 0 and 0", stall_cnt_o, flush_cnt_o);
    end
`endif
    @(negedge clk_i);
    idleInputs();
    rst_i = 1'b1;
    #2 checkOutput("after_reset", 0, 0, S_NONE);

    $display("[TB] table vectors");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i]);
      #2 checkOutput(vecs[i].name, vecs[i].fa, vecs[i].fb, vecs[i].strobes);
    end

    $display("[TB] load in EX then MEM then WB");
    nextCycle();
    id_rs2_i = 7; id_rs2_used_i = 1; ex_waddr_i = 7; ex_we_i = 1; ex_load_i = 1;
    #2 checkOutput("lu_seq_c1", 0, 1, S_LU);
    nextCycle();
    id_rs2_i = 7; id_rs2_used_i = 1; mem_waddr_i = 7; mem_we_i = 1; mem_load_i = 1;
    #2 checkOutput("lu_seq_c2", 0, 2, S_LU);
    nextCycle();
    id_rs2_i = 7; id_rs2_used_i = 1; wb_waddr_i = 7; wb_we_i = 1;
    #2 checkOutput("lu_seq_c3", 0, 3, S_NONE);

    $display("[TB] taken beq held by a load hazard");
    nextCycle();
    id_rs1_i = 5; id_rs1_used_i = 1; id_branch_op_i = 1; id_take_branch_i = 1;
    ex_waddr_i = 5; ex_we_i = 1; ex_load_i = 1;
    #2 checkOutput("beq_lu_c1", 1, 0, S_LU);
    nextCycle();
    id_rs1_i = 5; id_rs1_used_i = 1; id_branch_op_i = 1; id_take_branch_i = 1;
    mem_waddr_i = 5; mem_we_i = 1; mem_load_i = 1;
    #2 checkOutput("beq_lu_c2", 2, 0, S_LU);
    nextCycle();
    id_rs1_i = 5; id_rs1_used_i = 1; id_branch_op_i = 1; id_take_branch_i = 1;
    wb_waddr_i = 5; wb_we_i = 1;
    #2 checkOutput("beq_lu_c3", 3, 0, S_REDIR);
    nextCycle();
    #2 checkOutput("beq_gone", 0, 0, S_NONE);

    $display("[TB] memory wait during a jump");
    for (int c = 0; c < 3; c++) begin
      nextCycle();
      id_jump_op_i = 1; mem_busy_i = 1;
      #2 checkOutput($sformatf("busy_jump_c%0d", c), 0, 0, S_BUSY);
    end
    nextCycle();
    id_jump_op_i = 1;
    #2 checkOutput("jump_after_busy", 0, 0, S_REDIR);

    $display("[TB] exception while waiting on memory");
    nextCycle();
    mem_busy_i = 1;
    #2 checkOutput("mw_enter", 0, 0, S_BUSY);
    nextCycle();
    mem_busy_i = 1; exc_i = 1;
    #2 checkOutput("mw_exc", 0, 0, S_TRAP);
    nextCycle();
    #2 checkOutput("trap_c1", 0, 0, S_TRAP);
    nextCycle();
    #2 checkOutput("trap_c2", 0, 0, S_TRAP);
    nextCycle();
    #2 checkOutput("trap_done", 0, 0, S_NONE);

    $display("[TB] reset in the middle of a trap");
    nextCycle();
    exc_i = 1;
    #2 checkOutput("rst_trap_exc", 0, 0, S_TRAP);
    nextCycle();
    id_rs1_i = 5; id_rs1_used_i = 1; ex_waddr_i = 5; ex_we_i = 1;
    #1 checkOutput("rst_trap_in", 1, 0, S_TRAP);
    rst_i = 1'b0;
    #1 checkOutput("rst_trap_abort", 0, 0, S_NONE);
    @(negedge clk_i);
    idleInputs();
    rst_i = 1'b1;
    #2 checkOutput("rst_trap_run", 0, 0, S_NONE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
